// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache
// controller sitting between the CPU load/store path and memory port 1.
// One line = one 32-bit word held as 4 bytes, byte 0 at the lowest address.
//
// Ports:
//   clk, rst_b                  clock, async active-low reset
//   cpu_req/cpu_we/cpu_addr/    CPU request (held until cpu_ready)
//   cpu_wdata
//   flush                       invalidate all lines (IDLE only, wins over cpu_req)
//   cpu_rdata, cpu_ready        registered load data, one-cycle response pulse
//   mem_addr/mem_wdata/mem_we   memory port 1 request (0 outside FILL/WRITE)
//   mem_rdata                   combinational memory read data
//   hit_count, miss_count       saturating lookup statistics
module dcache_ctrl #(
  parameter int INDEX_BITS  = 4,
  parameter int MEM_LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_addr,
  input  logic [0:3][7:0]  cpu_wdata,
  input  logic             flush,
  output logic [0:3][7:0]  cpu_rdata,
  output logic             cpu_ready,
  output logic [31:0]      mem_addr,
  input  logic [0:3][7:0]  mem_rdata,
  output logic [0:3][7:0]  mem_wdata,
  output logic             mem_we,
  output logic [15:0]      hit_count,
  output logic [15:0]      miss_count
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 32 - INDEX_BITS - 2;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_FILL, S_WRITE, S_RESP
  } state_t;

  state_t state_q, state_d;

  logic [LINES-1:0]       valid_q;
  logic [TAG_W-1:0]       tag_q  [LINES];
  logic [0:3][7:0]        data_q [LINES];

  logic                   req_we_q;
  logic [31:0]            req_addr_q;
  logic [0:3][7:0]        req_wdata_q;
  logic [3:0]             cnt_q;

  logic [INDEX_BITS-1:0]  idx;
  logic [TAG_W-1:0]       req_tag;
  logic                   hit;
  logic                   cnt_zero;

  assign idx      = req_addr_q[INDEX_BITS+1:2];
  assign req_tag  = req_addr_q[31:INDEX_BITS+2];
  // Tags and valid bits cannot change between LOOKUP and WRITE (flush is only
  // honoured in IDLE), so the hit can simply be re-evaluated in WRITE.
  assign hit      = valid_q[idx] && (tag_q[idx] == req_tag);
  assign cnt_zero = (cnt_q == 4'd0);

  // State register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and memory-side outputs
  always_comb begin
    state_d   = state_q;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    cpu_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!flush && cpu_req) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (req_we_q)  state_d = S_WRITE;
        else if (hit)  state_d = S_RESP;
        else           state_d = S_FILL;
      end
      S_FILL: begin
        mem_addr = req_addr_q;
        if (cnt_zero) state_d = S_RESP;
      end
      S_WRITE: begin
        mem_addr  = req_addr_q;
        mem_wdata = req_wdata_q;
        mem_we    = cnt_zero;
        if (cnt_zero) state_d = S_RESP;
      end
      S_RESP: begin
        cpu_ready = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control datapath: latched request, wait counter, valid bits, stats
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      valid_q     <= '0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      cnt_q       <= '0;
      cpu_rdata   <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (flush) begin
            valid_q <= '0;
          end else if (cpu_req) begin
            req_we_q    <= cpu_we;
            req_addr_q  <= cpu_addr & ~32'h3;
            req_wdata_q <= cpu_wdata;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
          end else begin
            if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
          end
          if (!req_we_q && hit) cpu_rdata <= data_q[idx];
          cnt_q <= 4'(MEM_LATENCY);
        end
        S_FILL: begin
          if (!cnt_zero) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            valid_q[idx] <= 1'b1;
            cpu_rdata    <= mem_rdata;
          end
        end
        S_WRITE: begin
          if (!cnt_zero) cnt_q <= cnt_q - 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Line storage: no reset needed, valid bits gate every use
  always_ff @(posedge clk) begin
    if (state_q == S_FILL && cnt_zero) begin
      data_q[idx] <= mem_rdata;
      tag_q[idx]  <= req_tag;
    end else if (state_q == S_WRITE && cnt_zero && hit) begin
      data_q[idx] <= req_wdata_q;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;

  logic             clk = 1'b0;
  logic             rst_b;
  logic             cpu_req;
  logic             cpu_we;
  logic [31:0]      cpu_addr;
  logic [0:3][7:0]  cpu_wdata;
  logic             flush;
  logic [0:3][7:0]  cpu_rdata;
  logic             cpu_ready;
  logic [31:0]      mem_addr;
  logic [0:3][7:0]  mem_rdata;
  logic [0:3][7:0]  mem_wdata;
  logic             mem_we;
  logic [15:0]      hit_count;
  logic [15:0]      miss_count;

  int total = 0;
  int bad   = 0;

  // Memory attached to port 1 (written only by the DUT) and an independent
  // reference image updated by the bench from the stores it issues.
  logic [31:0] tbmem   [64];
  logic [31:0] ref_mem [64];
  logic [31:0] exp_q [$];

  dcache_ctrl #(.INDEX_BITS(4), .MEM_LATENCY(2)) dut (
    .clk(clk), .rst_b(rst_b), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .flush(flush),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  assign mem_rdata = tbmem[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) tbmem[mem_addr[7:2]] <= mem_wdata;

  // One CPU transaction, starting #1 after a posedge with the DUT in IDLE
  // (that cycle is cycle 0). Returns observed timing and data; ends #1 after
  // the posedge that lands back in IDLE.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     output int rdy, output int nwe, output int we_cyc,
                     output logic [31:0] we_addr, output logic [31:0] we_data,
                     output int ma_first, output int ma_last,
                     output logic [31:0] ma_val, output logic [31:0] rd);
    rdy = -1; nwe = 0; we_cyc = -1; we_addr = '0; we_data = '0;
    ma_first = -1; ma_last = -1; ma_val = '0; rd = '0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    if (we) ref_mem[addr[7:2]] = wd;
    else    exp_q.push_back(ref_mem[addr[7:2]]);
    for (int c = 1; c <= 30 && rdy < 0; c++) begin
      @(posedge clk); #1;
      if (mem_we) begin nwe++; we_cyc = c; we_addr = mem_addr; we_data = mem_wdata; end
      if (mem_addr != 32'h0) begin
        if (ma_first < 0) ma_first = c;
        ma_last = c; ma_val = mem_addr;
      end
      if (cpu_ready) begin rdy = c; rd = cpu_rdata; end
    end
    cpu_req = 1'b0;
    if (rdy < 0) begin
      total++; bad++;
      $display("FAIL txn_timeout addr=%h: no cpu_ready within 30 cycles", addr);
    end
    @(posedge clk); #1;
  endtask

  int rdy, nwe, we_cyc, ma_first, ma_last;
  logic [31:0] we_addr, we_data, ma_val, rd, exp;
  logic [15:0] miss0;

  task automatic test_reset();
    total++; if (cpu_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", cpu_ready); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%b want=0", mem_we); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr); end
    total++; if (cpu_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", cpu_rdata); end
    total++; if (hit_count !== 16'h0 || miss_count !== 16'h0) begin
      bad++; $display("FAIL reset_counts got=%0d/%0d want=0/0", hit_count, miss_count); end
  endtask

  task automatic test_load_miss();
    txn(1'b0, 32'h10, 32'h0, rdy, nwe, we_cyc, we_addr, we_data, ma_first, ma_last, ma_val, rd);
    exp = exp_q.pop_front();
    total++; if (rdy != 5) begin bad++; $display("FAIL miss_latency got=%0d want=5", rdy); end
    total++; if (ma_first != 2 || ma_last != 4 || ma_val !== 32'h10) begin
      bad++; $display("FAIL miss_mem_addr got=%0d..%0d %h want=2..4 00000010", ma_first, ma_last, ma_val); end
    total++; if (rd !== exp) begin bad++; $display("FAIL miss_rdata got=%h want=%h", rd, exp); end
    total++; if (miss_count !== 16'd1) begin bad++; $display("FAIL miss_count1 got=%0d want=1", miss_count); end
  endtask

  task automatic test_load_hit();
    txn(1'b0, 32'h10, 32'h0, rdy, nwe, we_cyc, we_addr, we_data, ma_first, ma_last, ma_val, rd);
    exp = exp_q.pop_front();
    total++; if (rdy != 2) begin bad++; $display("FAIL hit_latency got=%0d want=2", rdy); end
    total++; if (ma_first != -1) begin bad++; $display("FAIL hit_mem_addr got=cycle %0d want=none", ma_first); end
    total++; if (rd !== exp) begin bad++; $display("FAIL hit_rdata got=%h want=%h", rd, exp); end
    total++; if (hit_count !== 16'd1) begin bad++; $display("FAIL hit_count1 got=%0d want=1", hit_count); end
  endtask

  task automatic test_store_hit();
    txn(1'b1, 32'h12, 32'hAABBCCDD, rdy, nwe, we_cyc, we_addr, we_data, ma_first, ma_last, ma_val, rd);
    total++; if (nwe != 1 || we_cyc != 4) begin bad++; $display("FAIL st_we got=%0d@%0d want=1@4", nwe, we_cyc); end
    total++; if (we_addr !== 32'h10 || we_data !== 32'hAABBCCDD) begin
      bad++; $display("FAIL st_mem got=%h:%h want=00000010:aabbccdd", we_addr, we_data); end
    total++; if (rdy != 5) begin bad++; $display("FAIL st_latency got=%0d want=5", rdy); end
    txn(1'b0, 32'h10, 32'h0, rdy, nwe, we_cyc, we_addr, we_data, ma_first, ma_last, ma_val, rd);
    exp = exp_q.pop_front();
    total++; if (rdy != 2) begin bad++; $display("FAIL st_hit_reload_lat got=%0d want=2", rdy); end
    total++; if (rd !== exp) begin bad++; $display("FAIL st_hit_reload got=%h want=%h", rd, exp); end
    total++; if (hit_count !== 16'd3) begin bad++; $display("FAIL hit_count3 got=%0d want=3", hit_count); end
  endtask

  task automatic test_store_miss();
    txn(1'b1, 32'h50, 32'h01020304, rdy, nwe, we_cyc, we_addr, we_data, ma_first, ma_last, ma_val, rd);
    total++; if (nwe != 1 || we_addr !== 32'h50) begin
      bad++; $display("FAIL stm_we got=%0d %h want=1 00000050", nwe, we_addr); end
    txn(1'b0, 32'h50, 32'h0, rdy, nwe, we_cyc, we_addr, we_data, ma_first, ma_last, ma_val, rd);
    exp = exp_q.pop_front();
    total++; if (rdy != 5) begin bad++; $display("FAIL stm_no_alloc got=%0d want=5", rdy); end
    total++; if (rd !== exp) begin bad++; $display("FAIL stm_rdata got=%h want=%h", rd, exp); end
    total++; if (miss_count !== 16'd3) begin bad++; $display("FAIL miss_count3 got=%0d want=3", miss_count); end
  endtask

  task automatic test_alias();
    miss0 = miss_count;
    txn(1'b0, 32'h10, 32'h0, rdy, nwe, we_cyc, we_addr, we_data, ma_first, ma_last, ma_val, rd);
    exp = exp_q.pop_front();
    total++; if (rdy != 5 || rd !== exp) begin bad++; $display("FAIL alias_a got=%0d %h want=5 %h", rdy, rd, exp); end
    txn(1'b0, 32'h50, 32'h0, rdy, nwe, we_cyc, we_addr, we_data, ma_first, ma_last, ma_val, rd);
    exp = exp_q.pop_front();
    total++; if (rdy != 5 || rd !== exp) begin bad++; $display("FAIL alias_b got=%0d %h want=5 %h", rdy, rd, exp); end
    txn(1'b0, 32'h10, 32'h0, rdy, nwe, we_cyc, we_addr, we_data, ma_first, ma_last, ma_val, rd);
    exp = exp_q.pop_front();
    total++; if (rdy != 5 || rd !== exp) begin bad++; $display("FAIL alias_c got=%0d %h want=5 %h", rdy, rd, exp); end
    total++; if (miss_count - miss0 != 16'd3) begin
      bad++; $display("FAIL alias_misses got=%0d want=3", miss_count - miss0); end
  endtask

  task automatic test_flush();
    int seen;
    txn(1'b0, 32'h10, 32'h0, rdy, nwe, we_cyc, we_addr, we_data, ma_first, ma_last, ma_val, rd);
    exp = exp_q.pop_front();
    total++; if (rdy != 2 || rd !== exp) begin bad++; $display("FAIL pre_flush_hit got=%0d %h want=2 %h", rdy, rd, exp); end
    // flush together with a request: flush wins, no response
    flush = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    @(posedge clk); #1;
    flush = 1'b0; cpu_req = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (cpu_ready) seen++;
      @(posedge clk); #1;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL flush_ready got=%0d pulses want=0", seen); end
    txn(1'b0, 32'h10, 32'h0, rdy, nwe, we_cyc, we_addr, we_data, ma_first, ma_last, ma_val, rd);
    exp = exp_q.pop_front();
    total++; if (rdy != 5 || rd !== exp) begin bad++; $display("FAIL post_flush got=%0d %h want=5 %h", rdy, rd, exp); end
  endtask

  task automatic test_reset_mid_write();
    int pulses;
    pulses = 0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'hDEADBEEF;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      if (mem_we) pulses++;
    end
    // cycle 3: WRITE with one wait cycle left
    rst_b = 1'b0; cpu_req = 1'b0;
    #1;
    total++; if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      bad++; $display("FAIL rst_mid_mem got=%b %h %h want=0 0 0", mem_we, mem_addr, mem_wdata); end
    total++; if (cpu_ready !== 1'b0 || cpu_rdata !== 32'h0 || hit_count !== 16'h0 || miss_count !== 16'h0) begin
      bad++; $display("FAIL rst_mid_cpu got=%b %h %0d %0d want=0 0 0 0", cpu_ready, cpu_rdata, hit_count, miss_count); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (mem_we) pulses++;
    end
    rst_b = 1'b1;
    @(posedge clk); #1;
    if (mem_we) pulses++;
    total++; if (pulses != 0) begin bad++; $display("FAIL rst_abort_we got=%0d want=0", pulses); end
    total++; if (tbmem[8] !== ref_mem[8]) begin bad++; $display("FAIL rst_abort_mem got=%h want=%h", tbmem[8], ref_mem[8]); end
    txn(1'b0, 32'h10, 32'h0, rdy, nwe, we_cyc, we_addr, we_data, ma_first, ma_last, ma_val, rd);
    exp = exp_q.pop_front();
    total++; if (rdy != 5 || rd !== exp) begin bad++; $display("FAIL post_rst_load got=%0d %h want=5 %h", rdy, rd, exp); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin tbmem[i] = 32'h0; ref_mem[i] = 32'h0; end
    tbmem[4]  = 32'h11223344; ref_mem[4]  = 32'h11223344;
    tbmem[20] = 32'h55667788; ref_mem[20] = 32'h55667788;
    rst_b = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_b = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_load_miss();
    test_load_hit();
    test_store_hit();
    test_store_miss();
    test_alias();
    test_flush();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
